// File: rtl/store_rmw_ctrl_pkg.sv
// rtl/store_rmw_ctrl_pkg.sv - shared sizes, store-size codes and FSM states for the store sequencer
package store_rmw_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  localparam logic [1:0] SS_WORD = 2'b00;
  localparam logic [1:0] SS_BYTE = 2'b01;
  localparam logic [1:0] SS_HALF = 2'b10;
  localparam logic [1:0] SS_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/store_merge.sv
// rtl/store_merge.sv - merges store data into the low lane of the captured memory word
module store_merge
  import store_rmw_ctrl_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [DATA_W-1:0] mdr,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] merged
);

  // Byte/half always land in the low bits; the address offset never picks a lane.
  always_comb begin
    merged = b;
    case (size)
      SS_BYTE: merged = {mdr[DATA_W-1:8], b[7:0]};
      SS_HALF: merged = {mdr[DATA_W-1:16], b[15:0]};
      SS_RSVD: merged = mdr;
      default: merged = b;
    endcase
  end

endmodule

// File: rtl/store_rmw_ctrl.sv
// rtl/store_rmw_ctrl.sv - multicycle store sequencer: direct word writes, read-modify-write for byte/half
module store_rmw_ctrl
  import store_rmw_ctrl_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        store_size,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(MEM_LATENCY - 1);

  state_t             state;
  logic [DATA_W-1:2]  addr_q;
  logic [DATA_W-1:0]  b_q;
  logic [DATA_W-1:0]  mdr_q;
  logic [1:0]         size_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic [DATA_W-1:0]  merged;
  logic               unused_offset;

  // The byte offset is deliberately dropped: memory is word addressed and merges hit the low lane.
  assign unused_offset = ^addr[1:0];

  // Sequencer: latches the request in IDLE and steps READ/WAIT/WRITE/DONE with registered strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      b_q      <= '0;
      mdr_q    <= '0;
      size_q   <= '0;
      wait_cnt <= '0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_q <= addr[DATA_W-1:2];
            b_q    <= b_data;
            size_q <= store_size;
            busy   <= 1'b1;
            case (store_size)
              SS_WORD: begin
                state  <= ST_WRITE;
                mem_wr <= 1'b1;
              end
              SS_BYTE, SS_HALF: begin
                state  <= ST_READ;
                mem_rd <= 1'b1;
              end
              default: begin
                state <= ST_DONE;
                done  <= 1'b1;
                err   <= 1'b1;
              end
            endcase
          end
        end
        ST_READ: begin
          mem_rd   <= 1'b0;
          wait_cnt <= WAIT_INIT;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else begin
            mdr_q  <= mem_rdata;
            mem_wr <= 1'b1;
            state  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          mem_wr <= 1'b0;
          done   <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          done   <= 1'b0;
          err    <= 1'b0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  store_merge u_merge (
    .size   (size_q),
    .mdr    (mdr_q),
    .b      (b_q),
    .merged (merged)
  );

  // Address and write data come only from latched copies; both read as zero outside their use.
  assign mem_addr  = busy ? {addr_q, 2'b00} : '0;
  assign mem_wdata = mem_wr ? merged : '0;

endmodule
